// File: rtl/sram_axi_bridge_pkg.sv
// Shared types and constants for the SRAM-to-AXI3 bridge.
// Holds the read and write state encodings, the AXI IDs and the size helper.
package bridge_pkg;

   typedef enum logic [1:0] {
      R_IDLE = 2'd0,
      R_AR   = 2'd1,
      R_WAIT = 2'd2
   } rd_state_t;

   typedef enum logic [1:0] {
      W_IDLE   = 2'd0,
      W_SEND   = 2'd1,
      W_WAIT_B = 2'd2
   } wr_state_t;

   localparam logic [3:0] ID_INST = 4'd0;
   localparam logic [3:0] ID_DATA = 4'd1;

   // SRAM size 0/1/2 maps directly onto AXI 1/2/4-byte transfer sizes.
   function automatic logic [2:0] size_to_axi(input logic [1:0] size);
      return {1'b0, size};
   endfunction

endpackage

// File: rtl/sram_axi_bridge_if.sv
// AXI3 master-side signal bundle used by sram_axi_bridge (single-beat, 32-bit).
// Fixed fields (len, burst, lock, cache, prot, awid, wlast) are tied off outside the bridge.
interface sram_axi_bridge_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic [3:0]          arid;
   logic [ADDR_W-1:0]   araddr;
   logic [2:0]          arsize;
   logic                arvalid;
   logic                arready;

   logic [3:0]          rid;
   logic [DATA_W-1:0]   rdata;
   logic                rvalid;
   logic                rready;

   logic [ADDR_W-1:0]   awaddr;
   logic [2:0]          awsize;
   logic                awvalid;
   logic                awready;

   logic [DATA_W-1:0]   wdata;
   logic [DATA_W/8-1:0] wstrb;
   logic                wvalid;
   logic                wready;

   logic                bvalid;
   logic                bready;

   modport master (
      output arid, araddr, arsize, arvalid, input arready,
      input  rid, rdata, rvalid, output rready,
      output awaddr, awsize, awvalid, input awready,
      output wdata, wstrb, wvalid, input wready,
      input  bvalid, output bready
   );

   modport slave (
      input  arid, araddr, arsize, arvalid, output arready,
      output rid, rdata, rvalid, input rready,
      input  awaddr, awsize, awvalid, output awready,
      input  wdata, wstrb, wvalid, output wready,
      output bvalid, input bready
   );
endinterface

// File: rtl/sram_axi_bridge_wr_ctrl.sv
// Write side of the bridge: W_IDLE -> W_SEND -> W_WAIT_B, with independent AW/W handshakes.
// The latched awaddr doubles as the pending-write address for read-after-write checks.
module bridge_wr_ctrl
   import bridge_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                accept,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [1:0]          req_size,
   input  logic [DATA_W-1:0]   req_wdata,
   input  logic [DATA_W/8-1:0] req_wstrb,
   input  logic                b_block,
   output logic [ADDR_W-1:0]   awaddr,
   output logic [2:0]          awsize,
   output logic                awvalid,
   input  logic                awready,
   output logic [DATA_W-1:0]   wdata,
   output logic [DATA_W/8-1:0] wstrb,
   output logic                wvalid,
   input  logic                wready,
   input  logic                bvalid,
   output logic                bready,
   output logic                data_ok,
   output logic                busy
);

   wr_state_t state, state_next;
   logic      aw_done, w_done;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= W_IDLE;
         aw_done <= 1'b0;
         w_done  <= 1'b0;
         awaddr  <= '0;
         awsize  <= '0;
         wdata   <= '0;
         wstrb   <= '0;
      end else begin
         state <= state_next;
         if (accept) begin
            awaddr <= req_addr;
            awsize <= size_to_axi(req_size);
            wdata  <= req_wdata;
            wstrb  <= req_wstrb;
         end
         if (state != W_SEND) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
         end else begin
            if (awvalid && awready) aw_done <= 1'b1;
            if (wvalid && wready)   w_done  <= 1'b1;
         end
      end
   end

   // NOTE: every output gets a default first so no path through the case infers a latch.
   always_comb begin
      state_next = state;
      awvalid    = 1'b0;
      wvalid     = 1'b0;
      bready     = 1'b0;
      data_ok    = 1'b0;
      case (state)
         W_IDLE: begin
            if (accept) state_next = W_SEND;
         end
         W_SEND: begin
            awvalid = ~aw_done;
            wvalid  = ~w_done;
            if ((aw_done || awready) && (w_done || wready)) state_next = W_WAIT_B;
         end
         W_WAIT_B: begin
            // A same-cycle read response takes the data port; B waits one cycle.
            bready = ~b_block;
            if (bvalid && !b_block) begin
               data_ok    = 1'b1;
               state_next = W_IDLE;
            end
         end
         default: state_next = W_IDLE;
      endcase
   end

   assign busy = (state != W_IDLE);

endmodule

// File: rtl/sram_axi_bridge.sv
// Bridges the CPU inst (read-only) and data (read/write) SRAM-like ports onto one AXI3 master.
// Build option SRAM_AXI_RAW_CHECK_EN: inst reads may bypass a pending write to a different word.
module sram_axi_bridge
   import bridge_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                reset,

   input  logic                inst_req,
   input  logic [1:0]          inst_size,
   input  logic [ADDR_W-1:0]   inst_addr,
   output logic                inst_addr_ok,
   output logic                inst_data_ok,
   output logic [DATA_W-1:0]   inst_rdata,

   input  logic                data_req,
   input  logic                data_wr,
   input  logic [1:0]          data_size,
   input  logic [DATA_W/8-1:0] data_wstrb,
   input  logic [ADDR_W-1:0]   data_addr,
   input  logic [DATA_W-1:0]   data_wdata,
   output logic                data_addr_ok,
   output logic                data_data_ok,
   output logic [DATA_W-1:0]   data_rdata,

   sram_axi_bridge_if.master   axi
);

   rd_state_t         rd_state, rd_next;
   logic [3:0]        rd_id;
   logic [ADDR_W-1:0] rd_addr;
   logic [2:0]        rd_size;

   logic rd_idle, wr_busy, wr_ok, wr_accept, wr_data_ok;
   logic data_rd_accept, inst_accept, r_fire, rd_data_ok;
`ifdef SRAM_AXI_RAW_CHECK_EN
   logic raw_hit;
`endif

   // Acceptance: the data port never has two requests outstanding, and data reads beat inst reads.
   always_comb begin
      rd_idle        = (rd_state == R_IDLE);
      data_rd_accept = data_req && !data_wr && rd_idle && !wr_busy;
`ifdef SRAM_AXI_RAW_CHECK_EN
      wr_ok          = !wr_busy && (rd_idle || (rd_id == ID_INST));
      wr_accept      = data_req && data_wr && wr_ok;
      raw_hit        = wr_busy && (inst_addr[ADDR_W-1:2] == axi.awaddr[ADDR_W-1:2]);
      inst_accept    = inst_req && rd_idle && !raw_hit && !wr_accept && !data_rd_accept;
`else
      wr_ok          = !wr_busy && rd_idle;
      wr_accept      = data_req && data_wr && wr_ok;
      inst_accept    = inst_req && rd_idle && !wr_busy && !wr_accept && !data_rd_accept;
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_state <= R_IDLE;
         rd_id    <= ID_INST;
         rd_addr  <= '0;
         rd_size  <= '0;
      end else begin
         rd_state <= rd_next;
         if (data_rd_accept) begin
            rd_id   <= ID_DATA;
            rd_addr <= data_addr;
            rd_size <= size_to_axi(data_size);
         end else if (inst_accept) begin
            rd_id   <= ID_INST;
            rd_addr <= inst_addr;
            rd_size <= size_to_axi(inst_size);
         end
      end
   end

   always_comb begin
      rd_next      = rd_state;
      axi.arvalid  = 1'b0;
      axi.rready   = 1'b0;
      r_fire       = 1'b0;
      inst_data_ok = 1'b0;
      rd_data_ok   = 1'b0;
      inst_rdata   = '0;
      data_rdata   = '0;
      case (rd_state)
         R_IDLE: begin
            if (data_rd_accept || inst_accept) rd_next = R_AR;
         end
         R_AR: begin
            axi.arvalid = 1'b1;
            if (axi.arready) rd_next = R_WAIT;
         end
         R_WAIT: begin
            axi.rready = 1'b1;
            if (axi.rvalid) begin
               r_fire  = 1'b1;
               rd_next = R_IDLE;
               if (axi.rid == ID_INST) begin
                  inst_data_ok = 1'b1;
                  inst_rdata   = axi.rdata;
               end else begin
                  rd_data_ok = 1'b1;
                  data_rdata = axi.rdata;
               end
            end
         end
         default: rd_next = R_IDLE;
      endcase
   end

   assign axi.arid     = rd_id;
   assign axi.araddr   = rd_addr;
   assign axi.arsize   = rd_size;
   assign inst_addr_ok = inst_accept;
   assign data_addr_ok = data_rd_accept || wr_accept;
   assign data_data_ok = rd_data_ok || wr_data_ok;

   bridge_wr_ctrl #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_wr_ctrl (
      .clk       (clk),
      .reset     (reset),
      .accept    (wr_accept),
      .req_addr  (data_addr),
      .req_size  (data_size),
      .req_wdata (data_wdata),
      .req_wstrb (data_wstrb),
      .b_block   (r_fire),
      .awaddr    (axi.awaddr),
      .awsize    (axi.awsize),
      .awvalid   (axi.awvalid),
      .awready   (axi.awready),
      .wdata     (axi.wdata),
      .wstrb     (axi.wstrb),
      .wvalid    (axi.wvalid),
      .wready    (axi.wready),
      .bvalid    (axi.bvalid),
      .bready    (axi.bready),
      .data_ok   (wr_data_ok),
      .busy      (wr_busy)
   );

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed bench for sram_axi_bridge: the bench plays the AXI slave cycle by cycle.
// Inputs change 1 time unit after posedge; outputs are sampled on the negedge.
module tb_sram_axi_bridge;

   logic        clk = 1'b0;
   logic        reset;
   logic        inst_req;
   logic [1:0]  inst_size;
   logic [31:0] inst_addr;
   logic        inst_addr_ok, inst_data_ok;
   logic [31:0] inst_rdata;
   logic        data_req, data_wr;
   logic [1:0]  data_size;
   logic [3:0]  data_wstrb;
   logic [31:0] data_addr, data_wdata;
   logic        data_addr_ok, data_data_ok;
   logic [31:0] data_rdata;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sram_axi_bridge_if #(.ADDR_W(32), .DATA_W(32)) axi ();

   sram_axi_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk          (clk),
      .reset        (reset),
      .inst_req     (inst_req),
      .inst_size    (inst_size),
      .inst_addr    (inst_addr),
      .inst_addr_ok (inst_addr_ok),
      .inst_data_ok (inst_data_ok),
      .inst_rdata   (inst_rdata),
      .data_req     (data_req),
      .data_wr      (data_wr),
      .data_size    (data_size),
      .data_wstrb   (data_wstrb),
      .data_addr    (data_addr),
      .data_wdata   (data_wdata),
      .data_addr_ok (data_addr_ok),
      .data_data_ok (data_data_ok),
      .data_rdata   (data_rdata),
      .axi          (axi)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1;
      inst_req = 0; inst_size = 0; inst_addr = 0;
      data_req = 0; data_wr = 0; data_size = 0; data_wstrb = 0; data_addr = 0; data_wdata = 0;
      axi.arready = 0; axi.rid = 0; axi.rdata = 0; axi.rvalid = 0;
      axi.awready = 0; axi.wready = 0; axi.bvalid = 0;

      // Reset state
      tick(); tick(); sample();
      check("rst_inst_addr_ok", 32'(inst_addr_ok), 32'd0);
      check("rst_inst_data_ok", 32'(inst_data_ok), 32'd0);
      check("rst_inst_rdata",   inst_rdata,        32'd0);
      check("rst_data_addr_ok", 32'(data_addr_ok), 32'd0);
      check("rst_data_data_ok", 32'(data_data_ok), 32'd0);
      check("rst_data_rdata",   data_rdata,        32'd0);
      check("rst_arvalid",      32'(axi.arvalid),  32'd0);
      check("rst_araddr",       axi.araddr,        32'd0);
      check("rst_rready",       32'(axi.rready),   32'd0);
      check("rst_awvalid",      32'(axi.awvalid),  32'd0);
      check("rst_awaddr",       axi.awaddr,        32'd0);
      check("rst_wvalid",       32'(axi.wvalid),   32'd0);
      check("rst_wdata",        axi.wdata,         32'd0);
      check("rst_bready",       32'(axi.bready),   32'd0);
      reset = 1'b0;

      // 1: single inst read, zero-wait slave
      tick(); inst_req = 1; inst_size = 2; inst_addr = 32'h1C00_0000; axi.arready = 1;
      sample();
      check("t1_c0_inst_addr_ok", 32'(inst_addr_ok), 32'd1);
      check("t1_c0_arvalid",      32'(axi.arvalid),  32'd0);
      tick(); inst_req = 0;
      sample();
      check("t1_c1_arvalid", 32'(axi.arvalid), 32'd1);
      check("t1_c1_araddr",  axi.araddr,       32'h1C00_0000);
      check("t1_c1_arid",    32'(axi.arid),    32'd0);
      check("t1_c1_arsize",  32'(axi.arsize),  32'd2);
      tick(); axi.arready = 0; axi.rvalid = 1; axi.rid = 0; axi.rdata = 32'h0280_0C0C;
      sample();
      check("t1_c2_rready",       32'(axi.rready),   32'd1);
      check("t1_c2_inst_data_ok", 32'(inst_data_ok), 32'd1);
      check("t1_c2_inst_rdata",   inst_rdata,        32'h0280_0C0C);
      check("t1_c2_data_data_ok", 32'(data_data_ok), 32'd0);
      tick(); axi.rvalid = 0;
      sample();
      check("t1_c3_inst_data_ok", 32'(inst_data_ok), 32'd0);
      check("t1_c3_arvalid",      32'(axi.arvalid),  32'd0);

      // 2: inst and data read in the same cycle; data wins
      tick();
      inst_req = 1; inst_addr = 32'h1C00_0010;
      data_req = 1; data_wr = 0; data_size = 1; data_addr = 32'h0000_1000;
      axi.arready = 1;
      sample();
      check("t2_c0_data_addr_ok", 32'(data_addr_ok), 32'd1);
      check("t2_c0_inst_addr_ok", 32'(inst_addr_ok), 32'd0);
      tick(); data_req = 0;
      sample();
      check("t2_c1_arid",         32'(axi.arid),     32'd1);
      check("t2_c1_araddr",       axi.araddr,        32'h0000_1000);
      check("t2_c1_arsize",       32'(axi.arsize),   32'd1);
      check("t2_c1_inst_addr_ok", 32'(inst_addr_ok), 32'd0);
      tick(); axi.arready = 0; axi.rvalid = 1; axi.rid = 1; axi.rdata = 32'h1234_5678;
      sample();
      check("t2_c2_data_data_ok", 32'(data_data_ok), 32'd1);
      check("t2_c2_data_rdata",   data_rdata,        32'h1234_5678);
      check("t2_c2_inst_data_ok", 32'(inst_data_ok), 32'd0);
      check("t2_c2_inst_addr_ok", 32'(inst_addr_ok), 32'd0);
      tick(); axi.rvalid = 0; axi.arready = 1;
      sample();
      check("t2_c3_inst_addr_ok", 32'(inst_addr_ok), 32'd1);
      tick(); inst_req = 0;
      sample();
      check("t2_c4_arid",   32'(axi.arid), 32'd0);
      check("t2_c4_araddr", axi.araddr,    32'h1C00_0010);
      tick(); axi.arready = 0; axi.rvalid = 1; axi.rid = 0; axi.rdata = 32'hA5A5_A5A5;
      sample();
      check("t2_c5_inst_data_ok", 32'(inst_data_ok), 32'd1);
      check("t2_c5_inst_rdata",   inst_rdata,        32'hA5A5_A5A5);
      tick(); axi.rvalid = 0;

      // 3: write with AW and W completing in different cycles
      data_req = 1; data_wr = 1; data_size = 2; data_addr = 32'h80;
      data_wstrb = 4'b0011; data_wdata = 32'hDEAD_BEEF;
      sample();
      check("t3_c0_data_addr_ok", 32'(data_addr_ok), 32'd1);
      tick(); data_req = 0; axi.awready = 1;
      sample();
      check("t3_c1_awvalid", 32'(axi.awvalid), 32'd1);
      check("t3_c1_wvalid",  32'(axi.wvalid),  32'd1);
      check("t3_c1_awaddr",  axi.awaddr,       32'h80);
      check("t3_c1_awsize",  32'(axi.awsize),  32'd2);
      check("t3_c1_wdata",   axi.wdata,        32'hDEAD_BEEF);
      check("t3_c1_wstrb",   32'(axi.wstrb),   32'h3);
      tick(); axi.awready = 0; data_req = 1; data_wr = 0; data_addr = 32'h40;
      sample();
      check("t3_c2_awvalid",      32'(axi.awvalid),  32'd0);
      check("t3_c2_wvalid",       32'(axi.wvalid),   32'd1);
      check("t3_c2_data_blocked", 32'(data_addr_ok), 32'd0);
      tick(); data_req = 0; axi.wready = 1;
      sample();
      check("t3_c3_wvalid", 32'(axi.wvalid), 32'd1);
      check("t3_c3_bready", 32'(axi.bready), 32'd0);
      tick(); axi.wready = 0;
      sample();
      check("t3_c4_wvalid",       32'(axi.wvalid),   32'd0);
      check("t3_c4_bready",       32'(axi.bready),   32'd1);
      check("t3_c4_data_data_ok", 32'(data_data_ok), 32'd0);
      tick(); axi.bvalid = 1;
      sample();
      check("t3_c5_data_data_ok", 32'(data_data_ok), 32'd1);
      tick(); axi.bvalid = 0;
      sample();
      check("t3_c6_data_data_ok", 32'(data_data_ok), 32'd0);
      check("t3_c6_bready",       32'(axi.bready),   32'd0);

      // 4/5: pending write to 0x100 against inst reads
      tick();
      data_req = 1; data_wr = 1; data_addr = 32'h100; data_wdata = 32'h1; data_wstrb = 4'hF;
      sample();
      check("t4_c0_data_addr_ok", 32'(data_addr_ok), 32'd1);
      tick(); data_req = 0; inst_req = 1; inst_addr = 32'h100;
      sample();
      check("t4_c1_same_word_held", 32'(inst_addr_ok), 32'd0);
      tick(); inst_addr = 32'h200;
`ifdef SRAM_AXI_RAW_CHECK_EN
      sample();
      check("t4_c2_other_word_ok", 32'(inst_addr_ok), 32'd1);
      tick(); inst_req = 0; axi.arready = 1; axi.awready = 1; axi.wready = 1;
      sample();
      check("t4_c3_arvalid", 32'(axi.arvalid), 32'd1);
      check("t4_c3_araddr",  axi.araddr,       32'h200);
      tick();
      axi.arready = 0; axi.awready = 0; axi.wready = 0;
      axi.rvalid = 1; axi.rid = 0; axi.rdata = 32'h0200_DA7A; axi.bvalid = 1;
      sample();
      check("t5_c4_inst_data_ok", 32'(inst_data_ok), 32'd1);
      check("t5_c4_inst_rdata",   inst_rdata,        32'h0200_DA7A);
      check("t5_c4_bready",       32'(axi.bready),   32'd0);
      check("t5_c4_data_data_ok", 32'(data_data_ok), 32'd0);
      tick(); axi.rvalid = 0; inst_req = 1; inst_addr = 32'h100;
      sample();
      check("t5_c5_bready",         32'(axi.bready),   32'd1);
      check("t5_c5_data_data_ok",   32'(data_data_ok), 32'd1);
      check("t4_c5_same_word_held", 32'(inst_addr_ok), 32'd0);
      tick(); axi.bvalid = 0;
      sample();
      check("t4_c6_after_b_ok", 32'(inst_addr_ok), 32'd1);
      tick(); inst_req = 0; axi.arready = 1;
      sample();
      check("t4_c7_araddr", axi.araddr, 32'h100);
      tick(); axi.arready = 0; axi.rvalid = 1; axi.rid = 0; axi.rdata = 32'h0000_0001;
      sample();
      check("t4_c8_inst_rdata", inst_rdata, 32'h0000_0001);
      tick(); axi.rvalid = 0;
`else
      sample();
      check("t4_c2_serialised_held", 32'(inst_addr_ok), 32'd0);
      tick(); axi.awready = 1; axi.wready = 1;
      sample();
      check("t4_c3_serialised_held", 32'(inst_addr_ok), 32'd0);
      check("t4_c3_arvalid",         32'(axi.arvalid),  32'd0);
      tick(); axi.awready = 0; axi.wready = 0; axi.bvalid = 1;
      sample();
      check("t4_c4_data_data_ok", 32'(data_data_ok), 32'd1);
      check("t4_c4_bready",       32'(axi.bready),   32'd1);
      check("t4_c4_inst_held",    32'(inst_addr_ok), 32'd0);
      tick(); axi.bvalid = 0;
      sample();
      check("t4_c5_inst_addr_ok", 32'(inst_addr_ok), 32'd1);
      tick(); inst_req = 0; axi.arready = 1;
      sample();
      check("t4_c6_araddr", axi.araddr, 32'h200);
      tick(); axi.arready = 0; axi.rvalid = 1; axi.rid = 0; axi.rdata = 32'h0200_DA7A;
      sample();
      check("t4_c7_inst_rdata", inst_rdata, 32'h0200_DA7A);
      tick(); axi.rvalid = 0;
`endif

      // 6: reset while in R_WAIT, then a fresh read
      inst_req = 1; inst_size = 2; inst_addr = 32'h1C00_0020; axi.arready = 1;
      sample();
      check("t6_c0_inst_addr_ok", 32'(inst_addr_ok), 32'd1);
      tick(); inst_req = 0;
      tick(); axi.arready = 0; reset = 1;
      sample();
      check("t6_c2_rready", 32'(axi.rready), 32'd1);
      tick(); reset = 0; inst_req = 1; inst_addr = 32'h1C00_0040; axi.arready = 1;
      sample();
      check("t6_c3_rready",       32'(axi.rready),   32'd0);
      check("t6_c3_araddr",       axi.araddr,        32'd0);
      check("t6_c3_inst_addr_ok", 32'(inst_addr_ok), 32'd1);
      tick(); inst_req = 0;
      sample();
      check("t6_c4_araddr", axi.araddr, 32'h1C00_0040);
      tick(); axi.arready = 0; axi.rvalid = 1; axi.rid = 0; axi.rdata = 32'hCAFE_F00D;
      sample();
      check("t6_c5_inst_data_ok", 32'(inst_data_ok), 32'd1);
      check("t6_c5_inst_rdata",   inst_rdata,        32'hCAFE_F00D);
      tick(); axi.rvalid = 0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
